// File: rtl/alu_writeback_pkg.sv
// Shared constants for the ALU writeback slice: widths, PSR bit positions, flag groups.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_writeback_pkg;

    localparam int WIDTH = 16;   // result / register width
    localparam int REGS  = 16;   // number of general registers
    localparam int AW    = 4;    // register address width
    localparam int PSR_W = 5;    // PSR width

    // PSR bit positions
    localparam int PSR_C = 0;
    localparam int PSR_F = 1;
    localparam int PSR_L = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    // Flag groups written by the decoder's instruction classes
    localparam logic [PSR_W-1:0] MASK_ARITH = (PSR_W'(1) << PSR_C) | (PSR_W'(1) << PSR_F);
    localparam logic [PSR_W-1:0] MASK_SUB   = MASK_ARITH | (PSR_W'(1) << PSR_L);
    localparam logic [PSR_W-1:0] MASK_CMP   = (PSR_W'(1) << PSR_Z) | (PSR_W'(1) << PSR_N);

    // Replace only the flags selected by mask, keep the rest of the current PSR.
    function automatic logic [PSR_W-1:0] psr_merge(input logic [PSR_W-1:0] cur,
                                                   input logic [PSR_W-1:0] upd,
                                                   input logic [PSR_W-1:0] mask);
        return (cur & ~mask) | (upd & mask);
    endfunction

endpackage

// File: rtl/alu_writeback_regfile_2r1w.sv
// General register file: two combinational read ports, one synchronous write port.
// Latency: write visible on reads the cycle after the write edge; reads are zero-latency.
// Backpressure: none; the write port is accepted unconditionally.
// Ports: clk/reset (sync, active-high, clears every register), wr_en/wr_addr/wr_data,
//        rd_addr_a/rd_data_a, rd_addr_b/rd_data_b.
module regfile_2r1w
    import alu_writeback_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);

    logic [WIDTH-1:0] mem [REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry pending register committing into regfile + masked PSR merge.
// Latency: accepted entry commits at the next non-held edge; reads/psr_out see it at once via bypass.
// Backpressure: in_ready drops only while an entry is pending and hold is high.
// Ports: clk, reset (sync, active-high); in_valid/in_ready handshake with in_result, in_psr,
//        in_flag_mask, in_wr_en, in_wr_addr; hold freezes commit; rd_addr_a/b -> rd_data_a/b
//        (bypassed); psr_out (PSR incl. pending update); commit pulse; commit_count (wraps).
module alu_writeback
    import alu_writeback_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [PSR_W-1:0] in_psr,
    input  logic [PSR_W-1:0] in_flag_mask,
    input  logic             in_wr_en,
    input  logic [AW-1:0]    in_wr_addr,
    input  logic             hold,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic [PSR_W-1:0] psr_out,
    output logic             commit,
    output logic [15:0]      commit_count
);

    logic             pend_valid;
    logic             pend_wr_en;
    logic [WIDTH-1:0] pend_result;
    logic [PSR_W-1:0] pend_psr;
    logic [PSR_W-1:0] pend_mask;
    logic [AW-1:0]    pend_addr;
    logic [PSR_W-1:0] psr;
    logic [PSR_W-1:0] psr_merged;
    logic             accept;
    logic [WIDTH-1:0] rf_data_a;
    logic [WIDTH-1:0] rf_data_b;

    // The slot frees itself in the same edge it retires, so an empty or
    // retiring slot can always take a new entry: full rate while hold is low.
    assign in_ready   = !pend_valid || !hold;
    assign accept     = in_valid && in_ready;
    assign commit     = pend_valid && !hold;
    assign psr_merged = psr_merge(psr, pend_psr, pend_mask);
    assign psr_out    = pend_valid ? psr_merged : psr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid   <= 1'b0;
            pend_wr_en   <= 1'b0;
            pend_result  <= '0;
            pend_psr     <= '0;
            pend_mask    <= '0;
            pend_addr    <= '0;
            psr          <= '0;
            commit_count <= '0;
        end else begin
            if (accept) begin
                pend_valid  <= 1'b1;
                pend_wr_en  <= in_wr_en;
                pend_result <= in_result;
                pend_psr    <= in_psr;
                pend_mask   <= in_flag_mask;
                pend_addr   <= in_wr_addr;
            end else if (commit) begin
                pend_valid  <= 1'b0;
            end
            if (commit) begin
                psr          <= psr_merged;
                commit_count <= commit_count + 16'd1;
            end
        end
    end

    regfile_2r1w u_rf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (commit && pend_wr_en),
        .wr_addr   (pend_addr),
        .wr_data   (pend_result),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rf_data_a),
        .rd_data_b (rf_data_b)
    );

    // A pending write is architecturally ahead of the regfile; forward it.
    assign rd_data_a = (pend_valid && pend_wr_en && (pend_addr == rd_addr_a)) ? pend_result : rf_data_a;
    assign rd_data_b = (pend_valid && pend_wr_en && (pend_addr == rd_addr_b)) ? pend_result : rf_data_b;

endmodule
